vector_read_sequencer: RTL and testbench

//  Upstream stage of vector_ram. Accepts a read command (base index, beat count) and issues

---
 rtl/vector_pkg.sv | 21 ++
 rtl/vector_out_reg.sv | 55 +++++
 rtl/vector_read_sequencer.sv | 149 ++++++++++++++
 tb/tb_vector_read_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and address helper for the vector RAM read path.
package vector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  // Element index served by one lane of one beat. The sum is formed at full
  // 32-bit width and only then reduced, so wrap-around past the end of the
  // vector is silent.
  function automatic int unsigned lane_addr(input int unsigned base,
                                            input int unsigned beat,
                                            input int unsigned lane,
                                            input int unsigned par,
                                            input int unsigned vlen);
    return (base + beat * par + lane) % vlen;
  endfunction

endpackage

// File: rtl/vector_out_reg.sv
// Single-entry output register: holds one beat plus its last flag until the
// downstream side takes it. A new load may replace a beat that is leaving in
// the same cycle, which gives one beat per cycle at full throughput.
module vector_out_reg #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load wins over drain; data is only replaced on a load so it stays stable
  // while the beat waits for out_ready.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      last_d  = load_last;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_data  = data_q;

endmodule

// File: rtl/vector_read_sequencer.sv
// Turns one (base, beats) read command into a stream of multi-lane read
// requests to vector_ram and returns the read data as an ordered beat stream
// with a last flag, keeping at most MAX_OUTSTANDING requests unanswered.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. A valid, once raised, holds together with its payload until
// that transfer; ready may change freely and never depends on valid of the
// same interface.
module vector_read_sequencer
  import vector_pkg::*;
#(
  parameter  int VECTOR_LENGTH   = 32,
  parameter  int DATA_WIDTH      = 32,
  parameter  int PARALLELISM     = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int ADDR_WIDTH      = $clog2(VECTOR_LENGTH),
  localparam int CNT_WIDTH       = ADDR_WIDTH + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [ADDR_WIDTH-1:0]             cmd_base,
  input  logic [CNT_WIDTH-1:0]              cmd_beats,
  output logic [PARALLELISM*ADDR_WIDTH-1:0] req_addr,
  output logic                              req_write,
  output logic                              req_valid,
  input  logic                              req_ready,
  input  logic [PARALLELISM*DATA_WIDTH-1:0] resp_rdata,
  input  logic                              resp_rvalid,
  output logic                              resp_rready,
  output logic [PARALLELISM*DATA_WIDTH-1:0] out_data,
  output logic                              out_valid,
  output logic                              out_last,
  input  logic                              out_ready,
  output logic                              busy
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  beats_q, beats_d;
  logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_WIDTH-1:0]  resp_cnt_q, resp_cnt_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;

  logic req_fire;
  logic resp_fire;
  logic resp_take;
  logic out_fire;
  logic load_last;

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign req_write   = 1'b0;
  assign req_valid   = (state_q == ISSUE) && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign req_fire    = req_valid && req_ready;
  assign resp_rready = !out_valid || out_ready;
  assign resp_fire   = resp_rvalid && resp_rready;
  // A response with nothing outstanding is a protocol error: swallow it.
  assign resp_take   = resp_fire && (outstanding_q != '0);
  assign out_fire    = out_valid && out_ready;
  assign load_last   = (resp_cnt_q == beats_q - CNT_WIDTH'(1));

  // Lane addresses of the beat currently being issued.
  always_comb begin
    req_addr = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
        ADDR_WIDTH'(lane_addr(32'(base_q), 32'(issue_cnt_q), 32'(i),
                              PARALLELISM, VECTOR_LENGTH));
    end
  end

  // Next-state, command latch, issue/response counters and in-flight count.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    beats_d       = beats_q;
    issue_cnt_d   = issue_cnt_q;
    resp_cnt_d    = resp_cnt_q;
    outstanding_d = outstanding_q;

    if (resp_take) resp_cnt_d = resp_cnt_q + CNT_WIDTH'(1);

    case ({req_fire, resp_take})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          base_d      = cmd_base;
          beats_d     = cmd_beats;
          issue_cnt_d = '0;
          resp_cnt_d  = '0;
          if (cmd_beats != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (req_fire) begin
          issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
          if (issue_cnt_q + CNT_WIDTH'(1) == beats_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      beats_q       <= '0;
      issue_cnt_q   <= '0;
      resp_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      beats_q       <= beats_d;
      issue_cnt_q   <= issue_cnt_d;
      resp_cnt_q    <= resp_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  vector_out_reg #(
    .WIDTH (PARALLELISM*DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (resp_take),
    .load_data (resp_rdata),
    .load_last (load_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_vector_read_sequencer.sv
// Bench for vector_read_sequencer: a latency-configurable RAM model feeds
// responses, and a scoreboard holds the expected request addresses and output
// beats computed from the address formula and a reference memory image.
module tb_vector_read_sequencer;

  localparam int L  = 32;
  localparam int DW = 32;
  localparam int P  = 4;
  localparam int MO = 4;
  localparam int AW = 5;
  localparam int CW = 6;
  localparam int PA = P * AW;
  localparam int PW = P * DW;
  localparam int EW = PW + 1;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [CW-1:0] cmd_beats;
  logic [PA-1:0] req_addr;
  logic          req_write;
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] resp_rdata;
  logic          resp_rvalid;
  logic          resp_rready;
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;

  vector_read_sequencer #(
    .VECTOR_LENGTH   (L),
    .DATA_WIDTH      (DW),
    .PARALLELISM     (P),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_base    (cmd_base),
    .cmd_beats   (cmd_beats),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .resp_rdata  (resp_rdata),
    .resp_rvalid (resp_rvalid),
    .resp_rready (resp_rready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference memory, RAM model queues and scoreboard.
  logic [DW-1:0] mem [L];
  int            due_q[$];
  logic [PW-1:0] rd_q[$];
  logic [PA-1:0] exp_addr_q[$];
  logic [EW-1:0] exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int req_ready_pct = 100;
  int out_ready_pct = 100;
  bit out_hold_low = 1'b0;
  int outstanding_m = 0;
  int req_fires = 0;
  int out_fires = 0;
  bit cmd_fired = 1'b0;
  bit pend_hold = 1'b0;
  logic [PA-1:0] hold_addr;

  function automatic logic [PA-1:0] beat_addr(input int base, input int b);
    logic [PA-1:0] r;
    int a;
    r = '0;
    for (int i = 0; i < P; i++) begin
      a = (base + b * P + i) % L;
      r[i*AW +: AW] = a[AW-1:0];
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] beat_data(input logic [PA-1:0] av);
    logic [PW-1:0] d;
    for (int i = 0; i < P; i++) d[i*DW +: DW] = mem[av[i*AW +: AW]];
    return d;
  endfunction

  // One clock cycle: drive inputs, observe settled handshakes, advance.
  task automatic step();
    logic [PA-1:0] ea;
    logic [EW-1:0] eo;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      resp_rvalid = 1'b1;
      resp_rdata  = rd_q[0];
    end else begin
      resp_rvalid = 1'b0;
      resp_rdata  = '0;
    end
    req_ready = ($urandom_range(99) < req_ready_pct);
    out_ready = out_hold_low ? 1'b0 : ($urandom_range(99) < out_ready_pct);
    #1;
    if (cmd_valid && cmd_ready) begin
      cmd_fired = 1'b1;
      for (int b = 0; b < int'(cmd_beats); b++) begin
        ea = beat_addr(int'(cmd_base), b);
        exp_addr_q.push_back(ea);
        exp_q.push_back({(b == int'(cmd_beats) - 1), beat_data(ea)});
      end
    end
    if (pend_hold) begin
      total++;
      if (!req_valid || req_addr !== hold_addr) begin
        bad++;
        $display("FAIL req_hold: valid=%0b addr=%0h required valid=1 addr=%0h", req_valid, req_addr, hold_addr);
      end
    end
    pend_hold = req_valid && !req_ready;
    hold_addr = req_addr;
    if (req_valid && req_ready) begin
      total++;
      if (exp_addr_q.size() == 0) begin
        bad++;
        $display("FAIL req_addr: unexpected request addr=%0h, none required", req_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (req_addr !== ea) begin
          bad++;
          $display("FAIL req_addr: got=%0h required=%0h", req_addr, ea);
        end
      end
      due_q.push_back(cyc + lat);
      rd_q.push_back(beat_data(req_addr));
      outstanding_m++;
      req_fires++;
    end
    if (resp_rvalid && resp_rready) begin
      void'(due_q.pop_front());
      void'(rd_q.pop_front());
      if (outstanding_m > 0) outstanding_m--;
    end
    total++;
    if (outstanding_m > MO) begin
      bad++;
      $display("FAIL outstanding: got=%0d limit=%0d", outstanding_m, MO);
    end
    if (out_valid && out_ready) begin
      total++;
      out_fires++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat: unexpected beat last=%0b data=%0h", out_last, out_data);
      end else begin
        eo = exp_q.pop_front();
        if ({out_last, out_data} !== eo) begin
          bad++;
          $display("FAIL out_beat: got last=%0b data=%0h required last=%0b data=%0h",
                   out_last, out_data, eo[PW], eo[PW-1:0]);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue_cmd(input int base, input int beats);
    int n;
    n = 0;
    cmd_base  = AW'(base);
    cmd_beats = CW'(beats);
    cmd_valid = 1'b1;
    cmd_fired = 1'b0;
    while (!cmd_fired && n < 20) begin
      step();
      n++;
    end
    cmd_valid = 1'b0;
    total++;
    if (!cmd_fired) begin
      bad++;
      $display("FAIL cmd_accept: got fired=0 required fired=1");
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    total++;
    if (busy || exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      bad++;
      $display("FAIL drain: busy=%0b beats_left=%0d reqs_left=%0d required 0/0/0",
               busy, exp_q.size(), exp_addr_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_ready, busy, req_valid, out_valid, out_last, req_write} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctrl: got=%b required=100000",
               {cmd_ready, busy, req_valid, out_valid, out_last, req_write});
    end
    total++;
    if (out_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got=%0h required=0", out_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    int f0;
    lat = 1; req_ready_pct = 100; out_ready_pct = 100;
    f0 = out_fires;
    issue_cmd(0, 8);
    total++;
    if (req_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_req: got req_valid=%0b required=1", req_valid);
    end
    wait_idle(200);
    total++;
    if (out_fires - f0 != 8) begin
      bad++;
      $display("FAIL seq_beats: got=%0d required=8", out_fires - f0);
    end
  endtask

  task automatic test_wrap();
    int f0;
    lat = 2; req_ready_pct = 100; out_ready_pct = 100;
    f0 = out_fires;
    issue_cmd(28, 2);
    wait_idle(100);
    total++;
    if (out_fires - f0 != 2) begin
      bad++;
      $display("FAIL wrap_beats: got=%0d required=2", out_fires - f0);
    end
  endtask

  task automatic test_outstanding();
    int r0;
    lat = 10; req_ready_pct = 100; out_ready_pct = 100;
    issue_cmd(0, 8);
    r0 = req_fires;
    repeat (8) step();
    total++;
    if (req_fires - r0 != MO) begin
      bad++;
      $display("FAIL outstanding_cap: got=%0d reqs required=%0d", req_fires - r0, MO);
    end
    total++;
    if (req_valid !== 1'b0) begin
      bad++;
      $display("FAIL cap_req_valid: got=%0b required=0", req_valid);
    end
    wait_idle(400);
  endtask

  task automatic test_backpressure();
    int f0, n;
    logic [PW-1:0] held;
    lat = 1; req_ready_pct = 100; out_ready_pct = 100;
    f0 = out_fires;
    issue_cmd(8, 8);
    n = 0;
    while (out_fires - f0 < 3 && n < 50) begin step(); n++; end
    out_hold_low = 1'b1;
    n = 0;
    while (!out_valid && n < 5) begin step(); n++; end
    held = out_data;
    repeat (5) begin
      step();
      total++;
      if (out_valid !== 1'b1 || resp_rready !== 1'b0 || out_data !== held) begin
        bad++;
        $display("FAIL stall: valid=%0b rready=%0b data=%0h required 1/0/%0h",
                 out_valid, resp_rready, out_data, held);
      end
    end
    out_hold_low = 1'b0;
    wait_idle(200);
    total++;
    if (out_fires - f0 != 8) begin
      bad++;
      $display("FAIL stall_beats: got=%0d required=8", out_fires - f0);
    end
  endtask

  task automatic test_zero_beats();
    bit seen;
    seen = 1'b0;
    issue_cmd(5, 0);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_idle: cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
    end
    repeat (4) begin
      step();
      if (req_valid || out_valid) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL zero_activity: got activity=1 required=0");
    end
  endtask

  task automatic test_reset_mid();
    int f0, n;
    lat = 3; req_ready_pct = 100; out_ready_pct = 100;
    f0 = out_fires;
    issue_cmd(0, 8);
    n = 0;
    while (out_fires - f0 < 3 && n < 60) begin step(); n++; end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_ready, busy, req_valid, out_valid, out_last} !== 5'b10000 || out_data !== '0) begin
      bad++;
      $display("FAIL mid_reset: ctrl=%b data=%0h required ctrl=10000 data=0",
               {cmd_ready, busy, req_valid, out_valid, out_last}, out_data);
    end
    exp_q.delete();
    exp_addr_q.delete();
    outstanding_m = 0;
    pend_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    f0 = out_fires;
    n = 0;
    while (due_q.size() > 0 && n < 40) begin step(); n++; end
    total++;
    if (out_fires != f0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stale_resp: got beats=%0d valid=%0b required 0/0", out_fires - f0, out_valid);
    end
    f0 = out_fires;
    issue_cmd(4, 1);
    wait_idle(100);
    total++;
    if (out_fires - f0 != 1) begin
      bad++;
      $display("FAIL post_reset_beats: got=%0d required=1", out_fires - f0);
    end
  endtask

  task automatic test_random();
    int f0, base, beats;
    repeat (6) begin
      base = $urandom_range(L - 1);
      beats = $urandom_range(12, 1);
      lat = $urandom_range(6, 1);
      req_ready_pct = $urandom_range(100, 30);
      out_ready_pct = $urandom_range(100, 30);
      f0 = out_fires;
      issue_cmd(base, beats);
      wait_idle(2000);
      total++;
      if (out_fires - f0 != beats) begin
        bad++;
        $display("FAIL rand_beats: base=%0d got=%0d required=%0d", base, out_fires - f0, beats);
      end
    end
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < L; i++) mem[i] = $urandom;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_base = '0;
    cmd_beats = '0;
    req_ready = 1'b0;
    resp_rvalid = 1'b0;
    resp_rdata = '0;
    out_ready = 1'b0;
    hold_addr = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_outstanding();
    test_backpressure();
    test_zero_beats();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
